// File: rtl/alu_cmd_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : alu_cmd_sequencer
// Purpose  : Sequential initiator for a combinational ALU. Accepts one
//            command at a time over a valid/ready handshake, drives the
//            ALU operands from registers, captures result and flags one
//            cycle later and returns them over a second valid/ready
//            handshake. An accumulator holds the last legal result so a
//            command can chain on it (cmd_use_acc).
// Revision : 1.0 - initial release
// ----------------------------------------------------------------------------
// Ports:
//   clk, rst_n          clock / asynchronous active-low reset
//   cmd_valid/ready     command handshake (ready only while idle)
//   cmd_op, cmd_a,
//   cmd_b, cmd_use_acc  command payload
//   alu_a/b/op          registered operands to the ALU
//   alu_r, alu_*        ALU result and flags {gt_zero, sf, cf, zf}
//   rsp_valid/ready     response handshake
//   rsp_r/flags/err     captured result, flags, illegal-opcode marker
//   acc                 accumulator (result of last legal op)
//   op_count            completed legal ops, saturating at 255
// ============================================================================
module alu_cmd_sequencer #(
  parameter int W = 6
) (
  input  logic         clk,
  input  logic         rst_n,
  // command channel
  input  logic         cmd_valid,
  output logic         cmd_ready,
  input  logic [1:0]   cmd_op,
  input  logic [W-1:0] cmd_a,
  input  logic [W-1:0] cmd_b,
  input  logic         cmd_use_acc,
  // ALU side
  output logic [W-1:0] alu_a,
  output logic [W-1:0] alu_b,
  output logic [1:0]   alu_op,
  input  logic [W-1:0] alu_r,
  input  logic         alu_gt_zero,
  input  logic         alu_sf,
  input  logic         alu_cf,
  input  logic         alu_zf,
  // response channel
  output logic         rsp_valid,
  input  logic         rsp_ready,
  output logic [W-1:0] rsp_r,
  output logic [3:0]   rsp_flags,
  output logic         rsp_err,
  // status
  output logic [W-1:0] acc,
  output logic [7:0]   op_count
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t state;

  // An opcode with bit 1 set marks an illegal command.
  logic exec_illegal;
  assign exec_illegal = alu_op[1];

  // Single sequential process: state and every handshake/status output are
  // registered here, so no output depends combinationally on an input.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      cmd_ready <= 1'b1;
      rsp_valid <= 1'b0;
      rsp_r     <= '0;
      rsp_flags <= 4'd0;
      rsp_err   <= 1'b0;
      alu_a     <= '0;
      alu_b     <= '0;
      alu_op    <= 2'd0;
      acc       <= '0;
      op_count  <= 8'd0;
    end else begin
      case (state)
        IDLE: begin
          if (cmd_valid && cmd_ready) begin
            // Operand A comes from the accumulator as it stands at this
            // edge, i.e. the result of the previous legal operation.
            alu_a     <= cmd_use_acc ? acc : cmd_a;
            alu_b     <= cmd_b;
            alu_op    <= cmd_op;
            cmd_ready <= 1'b0;
            state     <= EXEC;
          end
        end

        EXEC: begin
          // The ALU has had a full cycle to settle on the registered
          // operands; capture whatever it presents, illegal ops included.
          rsp_r     <= alu_r;
          rsp_flags <= {alu_gt_zero, alu_sf, alu_cf, alu_zf};
          rsp_err   <= exec_illegal;
          if (!exec_illegal) begin
            acc <= alu_r;
            if (op_count != 8'hFF) begin
              op_count <= op_count + 8'd1;
            end
          end
          rsp_valid <= 1'b1;
          state     <= RESP;
        end

        RESP: begin
          // Response fields are untouched here, so they stay stable for
          // as long as the requester applies backpressure.
          if (rsp_valid && rsp_ready) begin
            rsp_valid <= 1'b0;
            cmd_ready <= 1'b1;
            state     <= IDLE;
          end
        end

        default: begin
          // Unused encoding: recover to an idle, response-free state.
          rsp_valid <= 1'b0;
          cmd_ready <= 1'b1;
          state     <= IDLE;
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_alu_cmd_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : tb_alu_cmd_sequencer
// Purpose  : Self-checking bench for alu_cmd_sequencer. Includes a small
//            behavioural ALU to close the loop, and a reference model of
//            the sequencer's observable results (accumulator, counter,
//            captured result/flags).
// Revision : 1.0 - initial release
// ============================================================================
module tb_alu_cmd_sequencer;

  localparam int W = 6;

  logic         clk;
  logic         rst_n;
  logic         cmd_valid;
  logic         cmd_ready;
  logic [1:0]   cmd_op;
  logic [W-1:0] cmd_a;
  logic [W-1:0] cmd_b;
  logic         cmd_use_acc;
  logic [W-1:0] alu_a;
  logic [W-1:0] alu_b;
  logic [1:0]   alu_op;
  logic [W-1:0] alu_r;
  logic         alu_gt_zero;
  logic         alu_sf;
  logic         alu_cf;
  logic         alu_zf;
  logic         rsp_valid;
  logic         rsp_ready;
  logic [W-1:0] rsp_r;
  logic [3:0]   rsp_flags;
  logic         rsp_err;
  logic [W-1:0] acc;
  logic [7:0]   op_count;

  int checks = 0;
  int errors = 0;

  alu_cmd_sequencer #(.W(W)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .cmd_valid   (cmd_valid),
    .cmd_ready   (cmd_ready),
    .cmd_op      (cmd_op),
    .cmd_a       (cmd_a),
    .cmd_b       (cmd_b),
    .cmd_use_acc (cmd_use_acc),
    .alu_a       (alu_a),
    .alu_b       (alu_b),
    .alu_op      (alu_op),
    .alu_r       (alu_r),
    .alu_gt_zero (alu_gt_zero),
    .alu_sf      (alu_sf),
    .alu_cf      (alu_cf),
    .alu_zf      (alu_zf),
    .rsp_valid   (rsp_valid),
    .rsp_ready   (rsp_ready),
    .rsp_r       (rsp_r),
    .rsp_flags   (rsp_flags),
    .rsp_err     (rsp_err),
    .acc         (acc),
    .op_count    (op_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural ALU: XNOR for op 00, rotate right by B[2:0] one bit at a
  // time for op 01, zero for illegal opcodes.
  always_comb begin
    logic [W-1:0] t;
    t = alu_a;
    case (alu_op)
      2'b00:   alu_r = ~(alu_a ^ alu_b);
      2'b01: begin
        for (int k = 0; k < 7; k++) begin
          if (k < int'(alu_b[2:0])) t = {t[0], t[W-1:1]};
        end
        alu_r = t;
      end
      default: alu_r = '0;
    endcase
    alu_gt_zero = (alu_r != '0);
    alu_sf      = alu_r[W-1];
    alu_cf      = 1'b0;
    alu_zf      = (alu_r == '0);
  end

  // ---------------- reference model ----------------
  logic [5:0] m_acc;
  int         m_cnt;
  logic [5:0] e_a, e_b, e_r;
  logic [1:0] e_op;
  logic [3:0] e_flags;
  logic       e_err;

  function automatic logic [5:0] ref_result(input logic [1:0] op,
                                            input logic [5:0] a,
                                            input logic [5:0] b);
    logic [11:0] d;
    int n;
    case (op)
      2'b00: return ~(a ^ b);
      2'b01: begin
        n = int'(b[2:0]) % 6;
        d = {a, a} >> n;
        return d[5:0];
      end
      default: return 6'd0;
    endcase
  endfunction

  task automatic check(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Drive a command while the DUT is idle and compute what it should do.
  task automatic present(input logic [1:0] op, input logic [5:0] a,
                         input logic [5:0] b, input logic ua);
    check("idle_cmd_ready", cmd_ready, 1);
    cmd_valid   = 1'b1;
    cmd_op      = op;
    cmd_a       = a;
    cmd_b       = b;
    cmd_use_acc = ua;
    e_a     = ua ? m_acc : a;
    e_b     = b;
    e_op    = op;
    e_r     = ref_result(op, e_a, b);
    e_flags = {e_r != 6'd0, e_r[5], 1'b0, e_r == 6'd0};
    e_err   = op[1];
  endtask

  task automatic expect_accept();
    check("accept_cmd_ready", cmd_ready, 0);
    check("accept_rsp_valid", rsp_valid, 0);
    check("accept_alu_a", alu_a, e_a);
    check("accept_alu_b", alu_b, e_b);
    check("accept_alu_op", alu_op, e_op);
  endtask

  task automatic expect_capture();
    if (!e_err) begin
      m_acc = e_r;
      if (m_cnt < 255) m_cnt++;
    end
    check("cap_rsp_valid", rsp_valid, 1);
    check("cap_rsp_r", rsp_r, e_r);
    check("cap_rsp_flags", rsp_flags, e_flags);
    check("cap_rsp_err", rsp_err, e_err);
    check("cap_acc", acc, m_acc);
    check("cap_op_count", op_count, m_cnt);
  endtask

  task automatic expect_release();
    rsp_ready = 1'b1;
    step();
    check("rel_rsp_valid", rsp_valid, 0);
    check("rel_cmd_ready", cmd_ready, 1);
    rsp_ready = 1'b0;
  endtask

  task automatic do_op(input logic [1:0] op, input logic [5:0] a,
                       input logic [5:0] b, input logic ua);
    present(op, a, b, ua);
    step();
    expect_accept();
    cmd_valid = 1'b0;
    step();
    expect_capture();
    expect_release();
  endtask

  task automatic check_reset_values(input string tag);
    check({tag, "_cmd_ready"}, cmd_ready, 1);
    check({tag, "_rsp_valid"}, rsp_valid, 0);
    check({tag, "_rsp_r"}, rsp_r, 0);
    check({tag, "_rsp_flags"}, rsp_flags, 0);
    check({tag, "_rsp_err"}, rsp_err, 0);
    check({tag, "_alu_a"}, alu_a, 0);
    check({tag, "_alu_b"}, alu_b, 0);
    check({tag, "_alu_op"}, alu_op, 0);
    check({tag, "_acc"}, acc, 0);
    check({tag, "_op_count"}, op_count, 0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [5:0] hold_a;
    rst_n = 1'b0;
    cmd_valid = 1'b0; cmd_op = 2'd0; cmd_a = '0; cmd_b = '0;
    cmd_use_acc = 1'b0; rsp_ready = 1'b0;
    m_acc = 6'd0; m_cnt = 0;
    repeat (2) step();
    check_reset_values("por");
    rst_n = 1'b1;
    step();

    // Reset asserted mid-EXEC must clear everything immediately.
    present(2'b00, 6'b111000, 6'b000111, 1'b0);
    step();
    expect_accept();
    cmd_valid = 1'b0;
    #2 rst_n = 1'b0;
    #1 check_reset_values("async");
    step();
    check("async_no_rsp", rsp_valid, 0);
    rst_n = 1'b1;
    m_acc = 6'd0; m_cnt = 0;
    step();

    // Directed vectors.
    do_op(2'b00, 6'b101100, 6'b100101, 1'b0);     // XNOR -> 110110, 1100
    check("xnor_r", rsp_r, 6'b110110);
    check("xnor_flags", rsp_flags, 4'b1100);
    do_op(2'b01, 6'b000011, 6'b000001, 1'b0);     // ror 1 -> 100001
    check("ror1_r", rsp_r, 6'b100001);
    check("ror1_flags", rsp_flags, 4'b1100);
    do_op(2'b01, 6'b111111, 6'b000010, 1'b1);     // chained ror 2
    check("chain_alu_a", alu_a, 6'b100001);
    check("chain_r", rsp_r, 6'b011000);
    check("chain_flags", rsp_flags, 4'b1000);
    do_op(2'b10, 6'b010101, 6'b001100, 1'b0);     // illegal
    check("ill_r", rsp_r, 6'b000000);
    check("ill_flags", rsp_flags, 4'b0001);
    check("ill_err", rsp_err, 1);
    check("ill_acc", acc, 6'b011000);
    check("ill_cnt", op_count, 3);
    do_op(2'b11, 6'b000001, 6'b000001, 1'b1);     // illegal with acc

    // Backpressure with a second command held pending.
    present(2'b00, 6'b001010, 6'b110011, 1'b0);
    step();
    expect_accept();
    hold_a = 6'b010111;
    cmd_op = 2'b01; cmd_a = hold_a; cmd_b = 6'b000111; cmd_use_acc = 1'b0;
    step();
    expect_capture();
    for (int i = 0; i < 5; i++) begin
      step();
      check("bp_rsp_valid", rsp_valid, 1);
      check("bp_rsp_r", rsp_r, e_r);
      check("bp_rsp_flags", rsp_flags, e_flags);
      check("bp_cmd_ready", cmd_ready, 0);
      check("bp_alu_a", alu_a, 6'b001010);
    end
    expect_release();
    present(2'b01, hold_a, 6'b000111, 1'b0);      // same values still held
    step();
    expect_accept();
    cmd_valid = 1'b0;
    step();
    expect_capture();
    expect_release();

    // Random mix including illegal opcodes and chaining.
    for (int i = 0; i < 40; i++) begin
      do_op(2'($urandom_range(0, 3)), 6'($urandom), 6'($urandom),
            1'($urandom_range(0, 1)));
    end

    // Saturation: 260 further legal operations.
    for (int i = 0; i < 260; i++) begin
      do_op(2'($urandom_range(0, 1)), 6'($urandom), 6'($urandom),
            1'($urandom_range(0, 1)));
    end
    check("sat_op_count", op_count, 255);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
